// File: rtl/load_store_unit_if.sv
// Word-organised data-memory port: request/grant handshake with a separate
// read-response strobe. The LSU is the master side.
interface load_store_unit_if #(
   parameter int DATA_W     = 32,
   parameter int DM_ADDRESS = 9
);
   logic                  mem_req;
   logic                  mem_we;
   logic [DM_ADDRESS-3:0] mem_addr;
   logic [3:0]            mem_be;
   logic [DATA_W-1:0]     mem_wdata;
   logic                  mem_gnt;
   logic                  mem_rvalid;
   logic [DATA_W-1:0]     mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store unit: byte-enabled word accesses to data
// memory, formatted load results, and a pipeline stall while busy.
//
// state  | meaning
// IDLE   | sample MemRead/MemWrite; fault check; launch request
// REQ    | mem_req held with stable fields until mem_gnt
// WAIT_R | load granted, waiting for mem_rvalid
// DONE   | one cycle with stall low so the pipeline advances
module load_store_unit #(
   parameter int DATA_W     = 32,
   parameter int DM_ADDRESS = 9
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [DM_ADDRESS-1:0] addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [2:0]            funct3,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  stall,
   output logic                  access_fault,
   load_store_unit_if.master     mem
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

   state_t            state, state_nxt;
   logic              access;
   logic              load_ok;
   logic              store_ok;
   logic              misalign;
   logic              fault_raw;
   logic              valid;
   logic [3:0]        be_nxt;
   logic [DATA_W-1:0] wdata_nxt;
   logic [2:0]        fmt_f3;
   logic [1:0]        fmt_off;
   logic [7:0]        lane_byte;
   logic [15:0]       lane_half;
   logic [DATA_W-1:0] load_val;

   always_comb begin
      access    = mem_read ^ mem_write;
      load_ok   = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      store_ok  = funct3 inside {3'b000, 3'b001, 3'b010};
      misalign  = ((funct3[1:0] == 2'b01) && addr[0]) ||
                  ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      fault_raw = (mem_read && mem_write) ||
                  (access && (misalign || (mem_read && !load_ok) ||
                              (mem_write && !store_ok)));
      valid     = (state == IDLE) && access && !fault_raw;
   end

   // Both combinational outputs are forced low while reset is held, even
   // though the held-reset state is IDLE and would otherwise evaluate inputs.
   assign access_fault = reset && (state == IDLE) && fault_raw;
   assign stall        = reset && (valid || (state == REQ) || (state == WAIT_R));

   always_comb begin
      be_nxt    = 4'b1111;
      wdata_nxt = wr_data;
      if (mem_write) begin
         case (funct3[1:0])
            2'b00: begin
               be_nxt    = 4'b0001 << addr[1:0];
               wdata_nxt = {4{wr_data[7:0]}};
            end
            2'b01: begin
               be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
               wdata_nxt = {2{wr_data[15:0]}};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      case (fmt_off)
         2'd0:    lane_byte = mem.mem_rdata[7:0];
         2'd1:    lane_byte = mem.mem_rdata[15:8];
         2'd2:    lane_byte = mem.mem_rdata[23:16];
         default: lane_byte = mem.mem_rdata[31:24];
      endcase
      lane_half = fmt_off[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
      case (fmt_f3)
         3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
         3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
         3'b100:  load_val = {24'd0, lane_byte};
         3'b101:  load_val = {16'd0, lane_half};
         default: load_val = mem.mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (valid) state_nxt = REQ;
         REQ:     if (mem.mem_gnt) state_nxt = mem.mem_we ? DONE : WAIT_R;
         WAIT_R:  if (mem.mem_rvalid) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_be    <= 4'b0000;
         mem.mem_wdata <= '0;
         fmt_f3        <= 3'b000;
         fmt_off       <= 2'b00;
         rd_data       <= '0;
      end else begin
         case (state)
            IDLE: if (valid) begin
               mem.mem_req   <= 1'b1;
               mem.mem_we    <= mem_write;
               mem.mem_addr  <= addr[DM_ADDRESS-1:2];
               mem.mem_be    <= be_nxt;
               mem.mem_wdata <= wdata_nxt;
               fmt_f3        <= funct3;
               fmt_off       <= addr[1:0];
            end
            REQ:     if (mem.mem_gnt) mem.mem_req <= 1'b0;
            WAIT_R:  if (mem.mem_rvalid) rd_data <= load_val;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: transaction-level reference model,
// per-cycle compare on the falling edge, directed plus randomized accesses.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read, mem_write;
   logic [8:0]  addr;
   logic [31:0] wr_data;
   logic [2:0]  funct3;
   logic [31:0] rd_data;
   logic        stall, access_fault;

   load_store_unit_if #(.DATA_W(32), .DM_ADDRESS(9)) bus ();

   load_store_unit #(.DATA_W(32), .DM_ADDRESS(9)) dut (
      .clk          (clk),
      .reset        (reset),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .addr         (addr),
      .wr_data      (wr_data),
      .funct3       (funct3),
      .rd_data      (rd_data),
      .stall        (stall),
      .access_fault (access_fault),
      .mem          (bus)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   bit          chk_en  = 0;
   logic        exp_stall, exp_fault, exp_req, exp_we;
   logic [6:0]  exp_addr;
   logic [3:0]  exp_be;
   logic [31:0] exp_wdata;
   logic [31:0] exp_rd = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic bit m_fault(bit rd, bit wr, logic [2:0] f3, logic [8:0] a);
      int sz  = int'(f3) % 4;
      int off = int'(a) % 4;
      if (rd && wr) return 1'b1;
      if (!rd && !wr) return 1'b0;
      if (rd && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
      if (wr && f3 > 3'd2) return 1'b1;
      if (sz == 1 && off % 2 != 0) return 1'b1;
      if (sz == 2 && off != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] m_be(bit wr, logic [2:0] f3, logic [8:0] a);
      int off = int'(a) % 4;
      if (!wr) return 4'hF;
      if (f3 == 3'd0) return 4'(1 << off);
      if (f3 == 3'd1) return (off >= 2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] wd);
      if (f3 == 3'd0) return (wd & 32'hFF) * 32'h0101_0101;
      if (f3 == 3'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] m_load(logic [2:0] f3, logic [8:0] a, logic [31:0] w);
      int off = int'(a) % 4;
      logic [31:0] b = (w >> (8 * off)) & 32'hFF;
      logic [31:0] h = (w >> (16 * (off / 2))) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
         3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return w;
      endcase
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("stall", {31'd0, stall}, {31'd0, exp_stall});
         chk("access_fault", {31'd0, access_fault}, {31'd0, exp_fault});
         chk("mem_req", {31'd0, bus.mem_req}, {31'd0, exp_req});
         chk("rd_data", rd_data, exp_rd);
         if (exp_req) begin
            chk("mem_we", {31'd0, bus.mem_we}, {31'd0, exp_we});
            chk("mem_addr", {25'd0, bus.mem_addr}, {25'd0, exp_addr});
            chk("mem_be", {28'd0, bus.mem_be}, {28'd0, exp_be});
            if (exp_we) chk("mem_wdata", bus.mem_wdata, exp_wdata);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // One instruction presented to the LSU. g = grant-wait cycles in REQ,
   // r = response-wait cycles in WAIT_R. Returns in the DONE cycle (or the
   // sampling cycle for faults / non-accesses). Stray gnt/rvalid are driven
   // wherever the unit must ignore them.
   task automatic run_access(input bit rd, input bit wr, input logic [8:0] a,
                             input logic [31:0] wd, input logic [2:0] f3,
                             input int g, input int r, input logic [31:0] rdata);
      bit flt = m_fault(rd, wr, f3, a);
      next_cycle();
      mem_read = rd; mem_write = wr; addr = a; wr_data = wd; funct3 = f3;
      bus.mem_gnt = 1'($urandom); bus.mem_rvalid = 1'($urandom); bus.mem_rdata = $urandom;
      exp_fault = flt; exp_stall = !flt && (rd ^ wr); exp_req = 1'b0;
      if (flt || !(rd ^ wr)) return;
      exp_we = wr; exp_addr = a[8:2]; exp_be = m_be(wr, f3, a); exp_wdata = m_wdata(f3, wd);
      for (int i = 0; i <= g; i++) begin
         next_cycle();
         bus.mem_gnt = (i == g); bus.mem_rvalid = 1'($urandom); bus.mem_rdata = $urandom;
         exp_req = 1'b1; exp_stall = 1'b1; exp_fault = 1'b0;
      end
      if (rd) begin
         for (int i = 0; i <= r; i++) begin
            next_cycle();
            bus.mem_gnt = 1'($urandom); bus.mem_rvalid = (i == r);
            bus.mem_rdata = (i == r) ? rdata : $urandom;
            exp_req = 1'b0; exp_stall = 1'b1;
         end
      end
      next_cycle();
      bus.mem_gnt = 1'($urandom); bus.mem_rvalid = 1'($urandom); bus.mem_rdata = $urandom;
      exp_req = 1'b0; exp_stall = 1'b0; exp_fault = 1'b0;
      if (rd) exp_rd = m_load(f3, a, rdata);
   endtask

   initial begin
      logic [2:0] lf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      reset = 1'b0;
      mem_read = 1'b1; mem_write = 1'b1; addr = 9'h002; wr_data = 32'hFFFF_FFFF; funct3 = 3'b010;
      bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
      #3;
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_fault", {31'd0, access_fault}, 32'd0);
      chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
      chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
      chk("rst_addr", {25'd0, bus.mem_addr}, 32'd0);
      chk("rst_be", {28'd0, bus.mem_be}, 32'd0);
      chk("rst_wdata", bus.mem_wdata, 32'd0);
      chk("rst_rd", rd_data, 32'd0);
      next_cycle(); next_cycle();
      reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
      exp_stall = 1'b0; exp_fault = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
      exp_addr = '0; exp_be = '0; exp_wdata = '0;
      chk_en = 1;

      // Directed cases with hand-computed results pinning the model.
      run_access(1, 0, 9'h010, 32'd0, 3'b010, 0, 0, 32'hDEAD_BEEF);
      chk("lw_lit", rd_data, 32'hDEAD_BEEF);
      chk("lw_model_lit", exp_rd, 32'hDEAD_BEEF);
      chk("lw_addr_lit", {25'd0, bus.mem_addr}, 32'h04);
      run_access(1, 0, 9'h013, 32'd0, 3'b000, 1, 2, 32'h80FF_0011);
      chk("lb_lit", rd_data, 32'hFFFF_FF80);
      run_access(1, 0, 9'h013, 32'd0, 3'b100, 0, 1, 32'h80FF_0011);
      chk("lbu_lit", rd_data, 32'h0000_0080);
      chk("sh_be_lit", {28'd0, m_be(1, 3'b001, 9'h006)}, 32'h0000_000C);
      chk("sh_wd_lit", m_wdata(3'b001, 32'h1234_ABCD), 32'hABCD_ABCD);
      run_access(0, 1, 9'h006, 32'h1234_ABCD, 3'b001, 3, 0, 32'd0);
      chk("sh_be_dut", {28'd0, bus.mem_be}, 32'h0000_000C);
      run_access(1, 0, 9'h002, 32'd0, 3'b010, 0, 0, 32'd0);
      run_access(1, 1, 9'h010, 32'd0, 3'b010, 0, 0, 32'd0);
      run_access(1, 0, 9'h010, 32'd0, 3'b011, 0, 0, 32'd0);
      run_access(0, 1, 9'h020, 32'h0000_C0DE, 3'b010, 0, 0, 32'd0);
      run_access(1, 0, 9'h022, 32'd0, 3'b101, 0, 0, 32'hBEEF_0000);
      chk("lhu_lit", rd_data, 32'h0000_BEEF);

      // Reset asserted while the load waits for its response.
      next_cycle();
      mem_read = 1'b1; mem_write = 1'b0; addr = 9'h040; funct3 = 3'b010;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
      exp_stall = 1'b1; exp_fault = 1'b0; exp_req = 1'b0;
      exp_we = 1'b0; exp_addr = 7'h10; exp_be = 4'hF;
      next_cycle();
      bus.mem_gnt = 1'b1; exp_req = 1'b1;
      next_cycle();
      bus.mem_gnt = 1'b0; exp_req = 1'b0;
      @(posedge clk); #2;
      chk_en = 0;
      reset = 1'b0;
      #1;
      chk("rstmid_stall", {31'd0, stall}, 32'd0);
      chk("rstmid_req", {31'd0, bus.mem_req}, 32'd0);
      chk("rstmid_rd", rd_data, 32'd0);
      exp_rd = 32'd0;
      mem_read = 1'b0;
      next_cycle(); next_cycle();
      reset = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
      exp_stall = 1'b0; exp_fault = 1'b0; exp_req = 1'b0;
      chk_en = 1;
      next_cycle();
      bus.mem_rvalid = 1'b0;
      run_access(1, 0, 9'h013, 32'd0, 3'b100, 0, 0, 32'h1234_5678);
      chk("post_rst_lbu", rd_data, 32'h0000_0012);

      // Randomized mix: mostly legal accesses, some faults and idle cycles.
      for (int n = 0; n < 200; n++) begin
         int k = $urandom_range(0, 9);
         bit rd = (k < 4) || (k == 8);
         bit wr = (k >= 4 && k < 8) || (k == 8);
         logic [8:0] a = 9'($urandom);
         logic [2:0] f3 = 3'($urandom);
         if ($urandom_range(0, 3) != 0) begin
            f3 = wr ? 3'($urandom_range(0, 2)) : lf[$urandom_range(0, 4)];
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
         end
         run_access(rd, wr, a, $urandom, f3, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      end

      next_cycle();
      mem_read = 1'b0; mem_write = 1'b0;
      exp_stall = 1'b0; exp_fault = 1'b0; exp_req = 1'b0;
      next_cycle();
      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
